cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Multi-cycle fetch/execute sequencer for the 8-bit CPU. Owns PC and instruction register,
//  fetches from instruction memory over a req/ack handshake, and drives the register-file /
//  ALU control strobes one instruction at a time. Adds the reg<->mem moves (00100/00101)
//  via a data-memory handshake; sits between imem/dmem and the register file/ALU datapath.
// PARAMETERS
//  PC_W      8   program counter / imem address width
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk        in   1     system clock; sole clock domain, all state updates on posedge
//  rst        in   1     synchronous, active-high reset
//  imemReq    out  1     instruction fetch request
//  imemAddr   out  PC_W  fetch address (= pc)
//  imemAck    in   1     fetch complete; imemData valid this cycle
//  imemData   in   8     instruction word: [7:3] opcode, [2:0] register select
//  dmemReq    out  1     data memory request
//  dmemWe     out  1     1 = write (store), 0 = read (load); valid while dmemReq
//  dmemAck    in   1     data access complete
//  regSel     out  3     register select (= IR[2:0])
//  aluSel     out  3     ALU function
//  Rin,Rout   out  1     register-file load / drive strobes
//  RAin,RCout out  1     A-load / C-drive strobes
//  genConst   out  1     constant generator drive
//  memToBus   out  1     dmem read data drives bus (load)
//  busToMem   out  1     bus drives dmem write data (store)
//  halted     out  1     sequencer in HALT
//  illegalOp  out  1     one-cycle pulse on undefined opcode
//  pc         out  PC_W  current program counter
// BEHAVIOUR
//  - All outputs registered. Reset: state FETCH, pc=RESET_PC, IR=8'hF8 (NOP), every strobe,
//    imemReq, dmemReq, dmemWe, halted, illegalOp = 0, aluSel=0. imemReq rises cycle after rst drops.
//  - FETCH: imemReq=1, imemAddr=pc held until imemAck. On ack: IR<=imemData, pc<=pc+1
//    (wraps 2^PC_W-1 -> 0), -> EXEC. imemAck outside FETCH ignored.
//  - EXEC (exactly 1 cycle, strobes valid only here):
//    00000 Rout,aluSel=000 | 00001 RCout,Rin | 00010 genConst,aluSel=000 | 00011 Rout,RAin
//    00110..01100 Rout, aluSel = not 001/and 010/or 011/xor 100/add 101/sub 110/inc 111
//    11111 NOP: no strobes | 11110 HALT: -> HALT | 00100/00101 -> MEM
//    other opcodes: no strobes, illegalOp=1 for this cycle, treat as NOP. Non-MEM/HALT -> FETCH.
//  - MEM: dmemReq=1 until dmemAck. Store (00100): dmemWe=1, Rout+busToMem held whole state.
//    Load (00101): dmemWe=0; memToBus+Rin asserted only in cycle after ack (1-cycle WB), -> FETCH.
//  - Throughput with zero-wait ack: 2 cycles/reg op, 3 store, 4 load.
//  - HALT: halted=1, no requests, pc frozen; exit only via rst.
//  - rst in any state (incl. mid-handshake): abandons transfer, requests drop next cycle.
// CONFIGURATION
//  SEQ_SINGLE_STEP_EN defined: extra input `step` (1b); FETCH does not assert imemReq until a
//    step=1 cycle is seen, one instruction per pulse; pulses while not in FETCH are dropped.
//  Undefined: no `step` port, free-running fetch.
// STRUCTURE
//  cpu_pkg: opcode localparams (5b), aluSel codes, state encoding (FETCH/EXEC/MEM/WB/HALT).
//  Sub-module cpu_op_decode: combinational IR -> strobe/aluSel/class (reg/mem/halt/illegal).
// TESTING
//  1 rst 3 cycles, imemAck tied 1, program {00010_000,00001_011} -> genConst then Rin,
//    RCout with regSel=3 in cycles 2 and 4; pc=2.
//  2 store 00100_010, dmemAck delayed 3 cycles -> dmemReq/dmemWe/Rout/busToMem high 4 cycles.
//  3 load 00101_101, ack 1 cycle -> memToBus+Rin one cycle after ack, regSel=5, next fetch.
//  4 PC_W=8, pc=8'hFF, NOP fetched -> pc=8'h00; opcode 01101 -> illegalOp 1-cycle pulse.
//  5 11110 -> halted=1, imemReq stays 0 for 20 cycles; rst asserted mid-dmem wait -> all 0, pc=0.
//  6 with SEQ_SINGLE_STEP_EN: no imemReq until step; 3 pulses -> exactly 3 instructions.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcodes, ALU codes, sequencer states and control payload for the 8-bit CPU.
package cpu_pkg;

  localparam int unsigned INSTR_W = 8;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned ALU_W   = 3;

  // Opcodes (IR[7:3])
  localparam logic [OP_W-1:0] OP_PASS  = 5'b00000;
  localparam logic [OP_W-1:0] OP_MOVC  = 5'b00001;
  localparam logic [OP_W-1:0] OP_CONST = 5'b00010;
  localparam logic [OP_W-1:0] OP_LDA   = 5'b00011;
  localparam logic [OP_W-1:0] OP_STORE = 5'b00100;
  localparam logic [OP_W-1:0] OP_LOAD  = 5'b00101;
  localparam logic [OP_W-1:0] OP_NOT   = 5'b00110;
  localparam logic [OP_W-1:0] OP_AND   = 5'b00111;
  localparam logic [OP_W-1:0] OP_OR    = 5'b01000;
  localparam logic [OP_W-1:0] OP_XOR   = 5'b01001;
  localparam logic [OP_W-1:0] OP_ADD   = 5'b01010;
  localparam logic [OP_W-1:0] OP_SUB   = 5'b01011;
  localparam logic [OP_W-1:0] OP_INC   = 5'b01100;
  localparam logic [OP_W-1:0] OP_HALT  = 5'b11110;
  localparam logic [OP_W-1:0] OP_NOP   = 5'b11111;

  // ALU op opcodes map to aluSel = opcode - OP_ALU_BASE (not=1 .. inc=7)
  localparam logic [OP_W-1:0] OP_ALU_BASE = 5'b00101;

  localparam logic [ALU_W-1:0] ALU_PASS = 3'b000;

  // IR reset value decodes as NOP
  localparam logic [INSTR_W-1:0] INSTR_RESET = 8'hF8;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } seq_state_e;

  typedef enum logic [2:0] {
    CLS_REG,
    CLS_STORE,
    CLS_LOAD,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  // Register-file / ALU control strobes for one instruction
  typedef struct packed {
    logic             rin;
    logic             rout;
    logic             ra_in;
    logic             rc_out;
    logic             gen_const;
    logic [ALU_W-1:0] alu_sel;
  } ctrl_t;

endpackage

// File: rtl/cpu_op_decode.sv
// Combinational opcode decode: opcode -> EXEC-cycle strobes, aluSel and instruction class.
module cpu_op_decode
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output ctrl_t           ctrl_c,
  output op_class_e       cls_c
);

  // Opcode table; anything not listed is illegal and drives no strobes
  always_comb begin
    ctrl_c = '0;
    cls_c  = CLS_REG;
    case (opcode)
      OP_PASS: begin
        ctrl_c.rout    = 1'b1;
        ctrl_c.alu_sel = ALU_PASS;
      end
      OP_MOVC: begin
        ctrl_c.rc_out = 1'b1;
        ctrl_c.rin    = 1'b1;
      end
      OP_CONST: begin
        ctrl_c.gen_const = 1'b1;
        ctrl_c.alu_sel   = ALU_PASS;
      end
      OP_LDA: begin
        ctrl_c.rout  = 1'b1;
        ctrl_c.ra_in = 1'b1;
      end
      OP_STORE: cls_c = CLS_STORE;
      OP_LOAD:  cls_c = CLS_LOAD;
      OP_NOT, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_INC: begin
        ctrl_c.rout    = 1'b1;
        ctrl_c.alu_sel = ALU_W'(opcode - OP_ALU_BASE);
      end
      OP_NOP:   cls_c = CLS_REG;
      OP_HALT:  cls_c = CLS_HALT;
      default:  cls_c = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns PC and IR, fetches over imem req/ack,
// runs reg<->mem moves over dmem req/ack and drives registered datapath strobes.
// Build option: SEQ_SINGLE_STEP_EN adds a `step` input; each step pulse seen in
// FETCH releases exactly one instruction fetch.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic               imemReq,
  output logic [PC_W-1:0]    imemAddr,
  input  logic               imemAck,
  input  logic [INSTR_W-1:0] imemData,
  output logic               dmemReq,
  output logic               dmemWe,
  input  logic               dmemAck,
  output logic [REG_W-1:0]   regSel,
  output logic [ALU_W-1:0]   aluSel,
  output logic               Rin,
  output logic               Rout,
  output logic               RAin,
  output logic               RCout,
  output logic               genConst,
  output logic               memToBus,
  output logic               busToMem,
  output logic               halted,
  output logic               illegalOp,
  output logic [PC_W-1:0]    pc
);

`ifdef SEQ_SINGLE_STEP_EN
  // Fetch waits for a step pulse; pulses outside FETCH are ignored
  localparam logic REQ_ON_ENTRY = 1'b0;
  logic req_start_c;
  assign req_start_c = step;
`else
  localparam logic REQ_ON_ENTRY = 1'b1;
  logic req_start_c;
  assign req_start_c = 1'b1;
`endif

  seq_state_e         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic               imem_req_q, imem_req_d;
  logic               dmem_req_q, dmem_req_d;
  logic               dmem_we_q, dmem_we_d;
  logic               mem_to_bus_q, mem_to_bus_d;
  logic               bus_to_mem_q, bus_to_mem_d;
  logic               halted_q, halted_d;
  logic               illegal_q, illegal_d;

  logic [OP_W-1:0]    dec_op_c;
  ctrl_t              dec_ctrl_c;
  op_class_e          dec_cls_c;
  logic               is_store_c;

  // Decode the incoming word during FETCH, the held IR otherwise
  assign dec_op_c   = (state_q == ST_FETCH) ? imemData[INSTR_W-1:REG_W]
                                            : ir_q[INSTR_W-1:REG_W];
  assign is_store_c = (dec_cls_c == CLS_STORE);

  cpu_op_decode u_dec (
    .opcode (dec_op_c),
    .ctrl_c (dec_ctrl_c),
    .cls_c  (dec_cls_c)
  );

  // Next state and next registered outputs; outputs are a function of the state entered
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    ctrl_d       = '0;
    imem_req_d   = 1'b0;
    dmem_req_d   = 1'b0;
    dmem_we_d    = 1'b0;
    mem_to_bus_d = 1'b0;
    bus_to_mem_d = 1'b0;
    halted_d     = 1'b0;
    illegal_d    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (imem_req_q && imemAck) begin
          ir_d      = imemData;
          pc_d      = pc_q + PC_W'(1);
          ctrl_d    = dec_ctrl_c;
          illegal_d = (dec_cls_c == CLS_ILLEGAL);
          state_d   = ST_EXEC;
        end else begin
          imem_req_d = imem_req_q | req_start_c;
        end
      end
      ST_EXEC: begin
        case (dec_cls_c)
          CLS_STORE, CLS_LOAD: begin
            state_d      = ST_MEM;
            dmem_req_d   = 1'b1;
            dmem_we_d    = is_store_c;
            ctrl_d.rout  = is_store_c;
            bus_to_mem_d = is_store_c;
          end
          CLS_HALT: begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
          default: begin
            state_d    = ST_FETCH;
            imem_req_d = REQ_ON_ENTRY;
          end
        endcase
      end
      ST_MEM: begin
        if (dmemAck) begin
          if (is_store_c) begin
            state_d    = ST_FETCH;
            imem_req_d = REQ_ON_ENTRY;
          end else begin
            state_d      = ST_WB;
            ctrl_d.rin   = 1'b1;
            mem_to_bus_d = 1'b1;
          end
        end else begin
          dmem_req_d   = 1'b1;
          dmem_we_d    = is_store_c;
          ctrl_d.rout  = is_store_c;
          bus_to_mem_d = is_store_c;
        end
      end
      ST_WB: begin
        state_d    = ST_FETCH;
        imem_req_d = REQ_ON_ENTRY;
      end
      ST_HALT: begin
        halted_d = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // State, PC, IR and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= INSTR_RESET;
      ctrl_q       <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      mem_to_bus_q <= 1'b0;
      bus_to_mem_q <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ctrl_q       <= ctrl_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      mem_to_bus_q <= mem_to_bus_d;
      bus_to_mem_q <= bus_to_mem_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
    end
  end

  assign imemReq   = imem_req_q;
  assign imemAddr  = pc_q;
  assign pc        = pc_q;
  assign regSel    = ir_q[REG_W-1:0];
  assign aluSel    = ctrl_q.alu_sel;
  assign Rin       = ctrl_q.rin;
  assign Rout      = ctrl_q.rout;
  assign RAin      = ctrl_q.ra_in;
  assign RCout     = ctrl_q.rc_out;
  assign genConst  = ctrl_q.gen_const;
  assign dmemReq   = dmem_req_q;
  assign dmemWe    = dmem_we_q;
  assign memToBus  = mem_to_bus_q;
  assign busToMem  = bus_to_mem_q;
  assign halted    = halted_q;
  assign illegalOp = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: opcode vector table plus hand-written
// handshake, wrap, halt and reset sequences.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imemReq;
  logic [7:0] imemAddr;
  logic       imemAck = 1'b0;
  logic [7:0] imemData;
  logic       dmemReq;
  logic       dmemWe;
  logic       dmemAck = 1'b0;
  logic [2:0] regSel;
  logic [2:0] aluSel;
  logic       Rin, Rout, RAin, RCout, genConst;
  logic       memToBus, busToMem, halted, illegalOp;
  logic [7:0] pc;
`ifdef SEQ_SINGLE_STEP_EN
  logic       step = 1'b0;
`endif

  logic       tie = 1'b0;
  logic [7:0] imem_drv = 8'hFF;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Tied-ack mode serves a tiny program by address; otherwise tasks drive the word
  always_comb begin
    if (tie) begin
      case (imemAddr)
        8'h00:   imemData = 8'h10;
        8'h01:   imemData = 8'h0B;
        default: imemData = 8'hFF;
      endcase
    end else begin
      imemData = imem_drv;
    end
  end

  cpu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SEQ_SINGLE_STEP_EN
    .step      (step),
`endif
    .imemReq   (imemReq),
    .imemAddr  (imemAddr),
    .imemAck   (imemAck),
    .imemData  (imemData),
    .dmemReq   (dmemReq),
    .dmemWe    (dmemWe),
    .dmemAck   (dmemAck),
    .regSel    (regSel),
    .aluSel    (aluSel),
    .Rin       (Rin),
    .Rout      (Rout),
    .RAin      (RAin),
    .RCout     (RCout),
    .genConst  (genConst),
    .memToBus  (memToBus),
    .busToMem  (busToMem),
    .halted    (halted),
    .illegalOp (illegalOp),
    .pc        (pc)
  );

  typedef struct {
    logic [7:0] instr;
    logic [2:0] alu;
    logic [5:0] strb;  // {Rin, Rout, RAin, RCout, genConst, illegalOp}
  } vec_t;

  vec_t vecs [15];

  function automatic logic [5:0] strobes();
    return {Rin, Rout, RAin, RCout, genConst, illegalOp};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outs", {imemReq, dmemReq, dmemWe, strobes(), memToBus, busToMem,
                       halted, aluSel, regSel}, 32'h0);
    check("rst_pc", {24'h0, pc}, 32'h0);
    rst = 1'b0;
  endtask

  // Wait (bounded) for a fetch request, ack it with instr; returns at the EXEC-cycle negedge
  task automatic fetch(input logic [7:0] instr);
    int n;
    n = 0;
    @(negedge clk);
    while (!imemReq && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imemReq) check("fetch_req_timeout", {31'h0, imemReq}, 32'h1);
    imem_drv = instr;
    imemAck  = 1'b1;
    @(negedge clk);
    imemAck  = 1'b0;
  endtask

  initial begin
    logic [7:0] ins;
    logic [2:0] rs;
    bit         ok;

    vecs[0]  = '{8'h01, 3'd0, 6'b010000};  // pass
    vecs[1]  = '{8'h0B, 3'd0, 6'b100100};  // RCout,Rin
    vecs[2]  = '{8'h10, 3'd0, 6'b000010};  // genConst
    vecs[3]  = '{8'h1F, 3'd0, 6'b011000};  // Rout,RAin
    vecs[4]  = '{8'h32, 3'd1, 6'b010000};  // not
    vecs[5]  = '{8'h38, 3'd2, 6'b010000};  // and
    vecs[6]  = '{8'h44, 3'd3, 6'b010000};  // or
    vecs[7]  = '{8'h4E, 3'd4, 6'b010000};  // xor
    vecs[8]  = '{8'h51, 3'd5, 6'b010000};  // add
    vecs[9]  = '{8'h5B, 3'd6, 6'b010000};  // sub
    vecs[10] = '{8'h65, 3'd7, 6'b010000};  // inc
    vecs[11] = '{8'hFA, 3'd0, 6'b000000};  // nop
    vecs[12] = '{8'h68, 3'd0, 6'b000001};  // 01101 illegal
    vecs[13] = '{8'h87, 3'd0, 6'b000001};  // 10000 illegal
    vecs[14] = '{8'hE9, 3'd0, 6'b000001};  // 11101 illegal

`ifdef SEQ_SINGLE_STEP_EN
    // Single-step: no fetch without a pulse; three pulses -> three instructions
    do_reset();
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (imemReq) ok = 1'b0;
    end
    check("step_idle_noreq", {31'h0, ok}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      check($sformatf("step%0d_req", k), {31'h0, imemReq}, 32'h1);
      imem_drv = 8'hFF;
      imemAck  = 1'b1;
      @(negedge clk);
      imemAck  = 1'b0;
      step     = 1'b1;  // lands in EXEC, must be dropped
      @(negedge clk);
      step = 1'b0;
      ok = 1'b1;
      repeat (4) begin
        if (imemReq) ok = 1'b0;
        @(negedge clk);
      end
      check($sformatf("step%0d_drop", k), {31'h0, ok}, 32'h1);
    end
    check("step_pc", {24'h0, pc}, 32'd3);
`else
    // 1: tied ack, two-instruction program
    imemAck = 1'b1;
    tie     = 1'b1;
    do_reset();
    @(negedge clk);
    check("t1_c1", {imemReq, strobes(), pc}, {1'b1, 6'b000000, 8'd0});
    @(negedge clk);
    check("t1_c2", {imemReq, strobes(), aluSel, regSel, pc},
                   {1'b0, 6'b000010, 3'd0, 3'd0, 8'd1});
    @(negedge clk);
    check("t1_c3", {imemReq, strobes()}, {1'b1, 6'b000000});
    @(negedge clk);
    check("t1_c4", {imemReq, strobes(), regSel, pc},
                   {1'b0, 6'b100100, 3'd3, 8'd2});
    imemAck = 1'b0;
    tie     = 1'b0;

    // Opcode table: EXEC-cycle strobes, then back to FETCH with strobes cleared
    do_reset();
    for (int i = 0; i < 15; i++) begin
      ins = vecs[i].instr;
      rs  = ins[2:0];
      fetch(ins);
      check($sformatf("vec%0d_exec", i), {imemReq, dmemReq, halted, aluSel, regSel, strobes()},
            {3'b000, vecs[i].alu, rs, vecs[i].strb});
      @(negedge clk);
      check($sformatf("vec%0d_next", i), {imemReq, aluSel, strobes()}, {1'b1, 3'd0, 6'd0});
    end

    // 2: store, dmemAck in the fourth MEM cycle
    fetch(8'h22);
    check("st_exec", {dmemReq, strobes()}, {1'b0, 6'd0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("st_mem%0d", i), {dmemReq, dmemWe, Rout, busToMem, memToBus, regSel},
            {4'hF, 1'b0, 3'd2});
      if (i == 3) dmemAck = 1'b1;
    end
    @(negedge clk);
    dmemAck = 1'b0;
    check("st_done", {dmemReq, Rout, busToMem, imemReq}, 4'b0001);

    // 3: load, zero-wait ack, 1-cycle write-back
    fetch(8'h2D);
    check("ld_exec", {dmemReq, memToBus, Rin}, 3'b000);
    @(negedge clk);
    check("ld_mem", {dmemReq, dmemWe, memToBus, Rin}, 4'b1000);
    dmemAck = 1'b1;
    @(negedge clk);
    dmemAck = 1'b0;
    check("ld_wb", {dmemReq, memToBus, Rin, regSel, imemReq}, {3'b011, 3'd5, 1'b0});
    @(negedge clk);
    check("ld_next", {memToBus, Rin, imemReq}, 3'b001);
    check("pc_after_table", {24'h0, pc}, 32'd17);

    // 4: PC wrap and illegal-op pulse
    do_reset();
    for (int i = 0; i < 255; i++) fetch(8'hF8);
    check("pc_ff", {24'h0, pc}, 32'hFF);
    fetch(8'hF8);
    check("pc_wrap", {24'h0, pc}, 32'h0);
    fetch(8'h68);
    check("illegal_pulse", {31'h0, illegalOp}, 32'h1);
    @(negedge clk);
    check("illegal_clear", {31'h0, illegalOp}, 32'h0);

    // 5: halt holds with no requests; reset mid dmem wait
    do_reset();
    fetch(8'hF0);
    check("halt_exec", {31'h0, halted}, 32'h0);
    @(negedge clk);
    check("halt_set", {halted, imemReq}, 2'b10);
    ok = 1'b1;
    imemAck = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (imemReq || dmemReq || !halted || pc != 8'd1) ok = 1'b0;
    end
    imemAck = 1'b0;
    check("halt_hold", {31'h0, ok}, 32'h1);
    do_reset();
    check("halt_exit", {31'h0, halted}, 32'h0);
    fetch(8'h22);
    @(negedge clk);
    check("mid_dmem", {31'h0, dmemReq}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_outs", {imemReq, dmemReq, dmemWe, strobes(), memToBus, busToMem, halted, pc},
          32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_refetch", {imemReq, dmemReq}, 2'b10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
